// File: rtl/reg_file32.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read ports, one write port.
// Each read port is 32 bit-slices of mux32 followed by an optional write-bypass select.

module mux32 (
    input  logic [31:0] d_i,
    input  logic [4:0]  sel_i,
    output logic        y_o
);

    assign y_o = d_i[sel_i];

endmodule

module reg_file32 #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    localparam logic BYP_EN = (BYPASS != 0);

    logic [WIDTH-1:0] regs_q [32];
    logic [31:0]      col_s  [WIDTH];
    logic [WIDTH-1:0] mux1_s;
    logic [WIDTH-1:0] mux2_s;
    logic             byp1_s;
    logic             byp2_s;

    // Register array: async clear, address 0 is never written so it reads 0 forever
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else if (we && (wa != 5'd0)) begin
            regs_q[wa] <= wd;
        end
    end

    // Transpose the array so each bit slice sees bit i of every register
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            for (int r = 0; r < 32; r++) begin
                col_s[b][r] = regs_q[r][b];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_slice
            mux32 u_mux_p1 (.d_i(col_s[g]), .sel_i(ra1), .y_o(mux1_s[g]));
            mux32 u_mux_p2 (.d_i(col_s[g]), .sel_i(ra2), .y_o(mux2_s[g]));
        end
    endgenerate

    assign byp1_s = BYP_EN && we && (wa != 5'd0) && (wa == ra1);
    assign byp2_s = BYP_EN && we && (wa != 5'd0) && (wa == ra2);

    // Post-mux 2:1 bypass select; outputs forced to 0 while reset is held
    always_comb begin
        rd1 = {WIDTH{1'b0}};
        rd2 = {WIDTH{1'b0}};
        if (!rst) begin
            rd1 = {WIDTH{1'b0}};
            rd2 = {WIDTH{1'b0}};
        end else begin
            rd1 = byp1_s ? wd : mux1_s;
            rd2 = byp2_s ? wd : mux2_s;
        end
    end

endmodule
